// File: rtl/motor_pulse_ctrl_pkg.sv
// Shared types and defaults for the motor pulse controller (package motor_pkg).
// Channel FSM state encoding and the default pulse length.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ch_state_e;

  // 0.5 s at 50 MHz
  localparam int DEF_PULSE_LEN = 25000000;

endpackage

// File: rtl/motor_pulse_ctrl_if.sv
// Channel request/drive bundle for motor_pulse_ctrl; duty exists only with MOTOR_PWM_EN.
interface motor_pulse_ctrl_if #(
  parameter int N_CH = 2
);
  import motor_pkg::*;

  // There is no valid/ready pair here. mot is a level-sensitive request
  // sampled every rising clk edge. A channel accepts it only from IDLE, and
  // drops it by deasserting mot. done is a single-cycle completion strobe
  // that carries no backpressure.
  logic [N_CH-1:0] mot;
  logic [N_CH-1:0] mot_out;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] done;
  ch_state_e       state [N_CH];
`ifdef MOTOR_PWM_EN
  logic [7:0]      duty;
`endif

  modport master (
    output mot,
`ifdef MOTOR_PWM_EN
    output duty,
`endif
    input  mot_out, busy, done, state
  );

  modport slave (
    input  mot,
`ifdef MOTOR_PWM_EN
    input  duty,
`endif
    output mot_out, busy, done, state
  );

endinterface

// File: rtl/motor_pulse_ctrl_channel.sv
// One motor channel: IDLE/RUN/HOLD FSM with a saturating pulse counter.
module motor_channel import motor_pkg::*; #(
  parameter int CNT_W     = 28,
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      mot,
  input  logic      pwm_on,
  output logic      mot_out,
  output logic      busy,
  output logic      done,
  output ch_state_e state
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PULSE_LEN);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mot_out <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (mot) begin
            state   <= RUN;
            cnt     <= CNT_W'(1);
            busy    <= 1'b1;
            mot_out <= pwm_on;
          end
        end
        RUN: begin
          // Release is tested first so an abort on the final count beats done.
          if (!mot) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            mot_out <= 1'b0;
          end else if (cnt == LAST) begin
            state   <= HOLD;
            busy    <= 1'b0;
            mot_out <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            mot_out <= pwm_on;
          end
        end
        HOLD: begin
          if (!mot) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          busy    <= 1'b0;
          mot_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/motor_pulse_ctrl.sv
// N_CH independent fixed-length motor pulse channels.
// Define MOTOR_PWM_EN to add a shared 8-bit PWM that chops mot_out while a channel runs.
module motor_pulse_ctrl import motor_pkg::*; #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 28,
  parameter int PULSE_LEN = DEF_PULSE_LEN
) (
  input logic               clk,
  input logic               rst,
  motor_pulse_ctrl_if.slave bus
);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("motor_pulse_ctrl: N_CH out of range 1..16");
  end
  if (PULSE_LEN < 1 || longint'(PULSE_LEN) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_len
    $error("motor_pulse_ctrl: PULSE_LEN must be in 1..2^CNT_W-1");
  end

  logic pwm_on;

`ifdef MOTOR_PWM_EN
  logic [7:0] pwm_cnt;

  // Free-running and shared, so every channel chops in phase.
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= 8'd0;
    else     pwm_cnt <= pwm_cnt + 8'd1;
  end

  assign pwm_on = (pwm_cnt < bus.duty);
`else
  assign pwm_on = 1'b1;
`endif

  logic [N_CH-1:0] mot_out_v;
  logic [N_CH-1:0] busy_v;
  logic [N_CH-1:0] done_v;
  ch_state_e       state_v [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    motor_channel #(
      .CNT_W     (CNT_W),
      .PULSE_LEN (PULSE_LEN)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .mot     (bus.mot[i]),
      .pwm_on  (pwm_on),
      .mot_out (mot_out_v[i]),
      .busy    (busy_v[i]),
      .done    (done_v[i]),
      .state   (state_v[i])
    );
  end

  assign bus.mot_out = mot_out_v;
  assign bus.busy    = busy_v;
  assign bus.done    = done_v;
  assign bus.state   = state_v;

endmodule

// File: doc/motor_pulse_ctrl.md
MOTOR_PULSE_CTRL -- requirements
Module: motor_pulse_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of independent motor channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 28, width of each channel pulse counter.
REQ-003 SHALL have parameter PULSE_LEN, default 25000000, output high time in clk cycles (0.5 s at 50 MHz).
REQ-004 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port: mot  input  N_CH  per-channel run request, level-sensitive, synchronous to clk.
REQ-007 SHALL have port: mot_out  output  N_CH  per-channel motor drive, registered.
REQ-008 SHALL have port: busy  output  N_CH  high while channel is in RUN.
REQ-009 SHALL have port: done  output  N_CH  one-cycle pulse when a channel completes a full pulse.
REQ-010 SHALL have port, only when MOTOR_PWM_EN is defined: duty  input  8  shared PWM duty, sampled every cycle.

Function
REQ-011 Each channel SHALL run an independent FSM with states IDLE, RUN and HOLD.
REQ-012 IDLE, mot[i]=1 at an edge: next state RUN, cnt=1, mot_out[i]=1, busy[i]=1.
REQ-013 RUN, mot[i]=1, cnt<PULSE_LEN: cnt increments by 1, mot_out[i] stays 1.
REQ-014 RUN, mot[i]=1, cnt==PULSE_LEN: next state HOLD, mot_out[i]=0, busy[i]=0, done[i]=1 for exactly one cycle.
REQ-015 mot_out[i] SHALL therefore be high for exactly PULSE_LEN consecutive cycles per uninterrupted request.
REQ-016 RUN, mot[i]=0: abort; next state IDLE, mot_out[i]=0, busy[i]=0, cnt=0, done[i] stays 0.
REQ-017 HOLD, mot[i]=1: remain in HOLD with mot_out[i]=0; no retrigger without release.
REQ-018 HOLD, mot[i]=0: next state IDLE; a new rising request SHALL start a fresh pulse the following edge.
REQ-019 Abort and completion on the same edge (mot[i]=0 while cnt==PULSE_LEN): abort SHALL win; done[i] stays 0.
REQ-020 Channels SHALL not interact; simultaneous requests on all channels SHALL all be honoured.
REQ-021 PULSE_LEN SHALL satisfy 1 <= PULSE_LEN <= 2^CNT_W-1; violation SHALL be flagged by an elaboration-time check; PULSE_LEN=1 yields a single-cycle pulse.
REQ-022 Counter SHALL never wrap; it saturates at PULSE_LEN by construction.

Reset
REQ-023 rst=1 at an edge: all channels IDLE, cnt=0, mot_out=0, busy=0, done=0, PWM counter=0.
REQ-024 rst asserted mid-RUN SHALL drop mot_out in the same edge with no done; after release a held-high mot SHALL start a new pulse on the first non-reset edge.

Configuration
REQ-025 Macro MOTOR_PWM_EN SHALL, when defined, add the duty port and a shared free-running 8-bit PWM counter (wraps 255->0).
REQ-026 With MOTOR_PWM_EN, mot_out[i] in RUN SHALL equal (pwm_cnt < duty); duty=0 gives constant 0, duty=255 gives 255/256 high; FSM timing, busy and done unchanged.
REQ-027 Without MOTOR_PWM_EN, no duty port, no PWM counter, mot_out[i] = busy[i].

Structure
REQ-028 A shared package motor_pkg SHALL hold the channel state enum (IDLE, RUN, HOLD) and the default PULSE_LEN constant.
REQ-029 Per-channel FSM and counter SHALL live in sub-module motor_channel, instantiated N_CH times by generate; PWM counter stays in the top.

Verification (PULSE_LEN=5, N_CH=2 unless stated)
REQ-030 mot=01 held 10 cycles -> mot_out[0] high exactly 5 cycles, done[0] one cycle on the falling edge of mot_out[0], channel 1 quiet.
REQ-031 mot[0] high 3 cycles then low -> mot_out[0] high 3 cycles, busy drops with it, done never asserted.
REQ-032 mot[0] held high 20 cycles, released 1 cycle, reasserted -> exactly two 5-cycle pulses, two done pulses.
REQ-033 mot=11 asserted together, then rst pulsed at cycle 2 of RUN -> both outputs low next edge, no done, fresh 5-cycle pulses after rst release.
REQ-034 MOTOR_PWM_EN, duty=64, PULSE_LEN=512 -> mot_out[0] high 128 of 512 RUN cycles, done at cycle 512; duty=0 -> mot_out stays 0, done still at 512.
REQ-035 PULSE_LEN=1 -> single-cycle mot_out and done on the following edge.
